round_sgf_ctrl: RTL and testbench



---
 rtl/round_sgf_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_round_sgf_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/round_sgf_ctrl.sv
// Rounding sequencer for the add/subtract datapath: directed rounding, increment,
// renormalisation on carry-out, overflow/inexact flags, valid/ack output handshake.
module round_sgf_ctrl #(
    parameter int SW = 24,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [SW-1:0] sgf_i,
    input  logic [EW-1:0] exp_i,
    input  logic [1:0]    grs_i,
    input  logic          sign_i,
    input  logic [1:0]    round_type_i,
    input  logic          ack_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [SW-1:0] sgf_o,
    output logic [EW-1:0] exp_o,
    output logic          overflow_o,
    output logic          inexact_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECIDE = 3'd1,
        ST_INC    = 3'd2,
        ST_NORM   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [EW-1:0] EXP_ONES = {EW{1'b1}};
    localparam logic [SW-1:0] SGF_HIDDEN = {1'b1, {(SW-1){1'b0}}};

    state_t        state_r, state_s;
    logic [SW-1:0] sgf_r;
    logic [EW-1:0] exp_r;
    logic [1:0]    grs_r;
    logic          sign_r;
    logic [1:0]    rt_r;
    logic          cap_s;

    logic          ready_r, ready_s;
    logic          valid_r, valid_s;
    logic [SW-1:0] sgf_o_r, sgf_o_s;
    logic [EW-1:0] exp_o_r, exp_o_s;
    logic          ovf_r, ovf_s;
    logic          inx_r, inx_s;

    logic          round_flag_s;
    logic [SW:0]   sum_s;
    logic [EW-1:0] exp_inc_s;

    // Directed rounding only rounds away from zero when the mode points the same way as the sign
    assign round_flag_s = (|grs_r) & (((rt_r == 2'b01) & sign_r) | ((rt_r == 2'b10) & ~sign_r));
    assign sum_s        = {1'b0, sgf_r} + {{SW{1'b0}}, 1'b1};
    assign exp_inc_s    = exp_r + {{(EW-1){1'b0}}, 1'b1};

    // Next-state and next-output decode
    always_comb begin
        state_s = state_r;
        cap_s   = 1'b0;
        valid_s = 1'b0;
        sgf_o_s = sgf_o_r;
        exp_o_s = exp_o_r;
        ovf_s   = ovf_r;
        inx_s   = inx_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s = ST_DECIDE;
                    cap_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DECIDE: begin
                inx_s = |grs_r;
                if (round_flag_s) begin
                    state_s = ST_INC;
                end else begin
                    state_s = ST_DONE;
                    sgf_o_s = sgf_r;
                    exp_o_s = exp_r;
                end
            end
            ST_INC: begin
                if (sum_s[SW]) begin
                    state_s = ST_NORM;
                end else begin
                    state_s = ST_DONE;
                    sgf_o_s = sum_s[SW-1:0];
                    exp_o_s = exp_r;
                end
            end
            ST_NORM: begin
                state_s = ST_DONE;
                // An all-ones exponent on entry saturates instead of wrapping to zero
                if ((exp_r == EXP_ONES) || (exp_inc_s == EXP_ONES)) begin
                    ovf_s   = 1'b1;
                    exp_o_s = EXP_ONES;
                    sgf_o_s = {SW{1'b0}};
                end else begin
                    ovf_s   = 1'b0;
                    exp_o_s = exp_inc_s;
                    sgf_o_s = SGF_HIDDEN;
                end
            end
            ST_DONE: begin
                // First DONE cycle presents the result; ack only counts once valid_o is visible
                if (ack_i && valid_r) begin
                    state_s = ST_IDLE;
                    ovf_s   = 1'b0;
                    inx_s   = 1'b0;
                    valid_s = 1'b0;
                end else begin
                    state_s = ST_DONE;
                    valid_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
            end
        endcase
        ready_s = (state_s == ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            sgf_o_r <= {SW{1'b0}};
            exp_o_r <= {EW{1'b0}};
            ovf_r   <= 1'b0;
            inx_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= ready_s;
            valid_r <= valid_s;
            sgf_o_r <= sgf_o_s;
            exp_o_r <= exp_o_s;
            ovf_r   <= ovf_s;
            inx_r   <= inx_s;
        end
    end

    // Operand capture on accept
    always_ff @(posedge clk) begin
        if (!rst) begin
            sgf_r  <= {SW{1'b0}};
            exp_r  <= {EW{1'b0}};
            grs_r  <= 2'b00;
            sign_r <= 1'b0;
            rt_r   <= 2'b00;
        end else if (cap_s) begin
            sgf_r  <= sgf_i;
            exp_r  <= exp_i;
            grs_r  <= grs_i;
            sign_r <= sign_i;
            rt_r   <= round_type_i;
        end else begin
            sgf_r  <= sgf_r;
            exp_r  <= exp_r;
            grs_r  <= grs_r;
            sign_r <= sign_r;
            rt_r   <= rt_r;
        end
    end

    assign ready_o    = ready_r;
    assign valid_o    = valid_r;
    assign sgf_o      = sgf_o_r;
    assign exp_o      = exp_o_r;
    assign overflow_o = ovf_r;
    assign inexact_o  = inx_r;

endmodule

// File: tb/tb_round_sgf_ctrl.sv
// Scoreboard bench for round_sgf_ctrl: directed operands, expected results queued
// at launch and checked by an independent monitor when valid_o rises.
module tb_round_sgf_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [23:0] sgf_i;
    logic [7:0]  exp_i;
    logic [1:0]  grs_i;
    logic        sign_i;
    logic [1:0]  round_type_i;
    logic        ack_i;
    logic        ready_o;
    logic        valid_o;
    logic [23:0] sgf_o;
    logic [7:0]  exp_o;
    logic        overflow_o;
    logic        inexact_o;

    typedef struct packed {
        logic [23:0] sgf;
        logic [7:0]  e;
        logic        ovf;
        logic        inx;
        logic [31:0] lat;
        logic [31:0] start_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] cyc = 32'd0;
    logic        valid_q = 1'b0;

    round_sgf_ctrl #(.SW(24), .EW(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .sgf_i(sgf_i), .exp_i(exp_i),
        .grs_i(grs_i), .sign_i(sign_i), .round_type_i(round_type_i), .ack_i(ack_i),
        .ready_o(ready_o), .valid_o(valid_o), .sgf_o(sgf_o), .exp_o(exp_o),
        .overflow_o(overflow_o), .inexact_o(inexact_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares each new result against the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst && valid_o && !valid_q) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sgf_o", {8'd0, sgf_o}, {8'd0, e.sgf});
                check("exp_o", {24'd0, exp_o}, {24'd0, e.e});
                check("overflow_o", {31'd0, overflow_o}, {31'd0, e.ovf});
                check("inexact_o", {31'd0, inexact_o}, {31'd0, e.inx});
                check("latency", cyc - e.start_cyc, e.lat);
                check("ready_in_done", {31'd0, ready_o}, 32'd0);
            end
        end
        valid_q <= rst & valid_o;
    end

    task automatic launch(input logic [23:0] s, input logic [7:0] e, input logic [1:0] g,
                          input logic sg, input logic [1:0] rt);
        @(negedge clk);
        sgf_i = s; exp_i = e; grs_i = g; sign_i = sg; round_type_i = rt;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic run_op(input logic [23:0] s, input logic [7:0] e, input logic [1:0] g,
                          input logic sg, input logic [1:0] rt,
                          input logic [23:0] x_sgf, input logic [7:0] x_exp,
                          input logic x_ovf, input logic x_inx, input int lat, input int hold);
        exp_t        item;
        logic [23:0] h_sgf;
        logic [7:0]  h_exp;
        logic        h_ovf, h_inx;
        launch(s, e, g, sg, rt);
        item = '{sgf: x_sgf, e: x_exp, ovf: x_ovf, inx: x_inx, lat: lat, start_cyc: cyc};
        sb_q.push_back(item);
        for (int i = 0; i < 20 && !valid_o; i++) @(negedge clk);
        @(negedge clk);
        check("valid_timeout", {31'd0, valid_o}, 32'd1);
        if (hold > 0) begin
            h_sgf = sgf_o; h_exp = exp_o; h_ovf = overflow_o; h_inx = inexact_o;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                start_i = i[0];
                sgf_i = 24'h5A5A5A; exp_i = 8'h11; grs_i = 2'b11; sign_i = 1'b0; round_type_i = 2'b10;
            end
            @(negedge clk);
            start_i = 1'b0;
            check("hold_valid", {31'd0, valid_o}, 32'd1);
            check("hold_ready", {31'd0, ready_o}, 32'd0);
            check("hold_sgf", {8'd0, sgf_o}, {8'd0, h_sgf});
            check("hold_exp", {24'd0, exp_o}, {24'd0, h_exp});
            check("hold_flags", {30'd0, overflow_o, inexact_o}, {30'd0, h_ovf, h_inx});
        end
        @(negedge clk);
        ack_i = 1'b1;
        @(posedge clk);
        #1 ack_i = 1'b0;
        check("post_ack_valid", {31'd0, valid_o}, 32'd0);
        check("post_ack_ready", {31'd0, ready_o}, 32'd1);
        check("post_ack_flags", {30'd0, overflow_o, inexact_o}, 32'd0);
        check("post_ack_sgf_hold", {8'd0, sgf_o}, {8'd0, x_sgf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start_i = 1'b1; ack_i = 1'b0;
        sgf_i = 24'h800001; exp_i = 8'h80; grs_i = 2'b11; sign_i = 1'b0; round_type_i = 2'b10;
        // T1: reset held two cycles with start asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_outputs", {sgf_o, exp_o}, 32'd0);
        check("rst_flags", {30'd0, overflow_o, inexact_o}, 32'd0);
        start_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // T2..T5 and extra rounding-mode corners
        run_op(24'h800001, 8'h80, 2'b11, 1'b0, 2'b00, 24'h800001, 8'h80, 1'b0, 1'b1, 2, 0);
        run_op(24'h800001, 8'h80, 2'b01, 1'b0, 2'b10, 24'h800002, 8'h80, 1'b0, 1'b1, 3, 0);
        run_op(24'hFFFFFF, 8'h80, 2'b10, 1'b1, 2'b01, 24'h800000, 8'h81, 1'b0, 1'b1, 4, 0);
        run_op(24'hFFFFFF, 8'hFE, 2'b01, 1'b0, 2'b10, 24'h000000, 8'hFF, 1'b1, 1'b1, 4, 0);
        run_op(24'hFFFFFF, 8'hFE, 2'b01, 1'b1, 2'b10, 24'hFFFFFF, 8'hFE, 1'b0, 1'b1, 2, 0);
        run_op(24'hFFFFFF, 8'hFF, 2'b01, 1'b0, 2'b10, 24'h000000, 8'hFF, 1'b1, 1'b1, 4, 0);
        run_op(24'h123456, 8'h10, 2'b11, 1'b1, 2'b11, 24'h123456, 8'h10, 1'b0, 1'b1, 2, 0);
        run_op(24'hABCDEF, 8'h3C, 2'b00, 1'b0, 2'b10, 24'hABCDEF, 8'h3C, 1'b0, 1'b0, 2, 0);
        run_op(24'h9ABCDE, 8'h40, 2'b11, 1'b0, 2'b01, 24'h9ABCDE, 8'h40, 1'b0, 1'b1, 2, 0);
        run_op(24'h9ABCDE, 8'h40, 2'b10, 1'b1, 2'b01, 24'h9ABCDF, 8'h40, 1'b0, 1'b1, 3, 0);

        // T6: held DONE with start pulses, then abort in INC
        run_op(24'h800001, 8'h80, 2'b01, 1'b0, 2'b10, 24'h800002, 8'h80, 1'b0, 1'b1, 3, 10);
        launch(24'h800001, 8'h80, 2'b01, 1'b0, 2'b10);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ready", {31'd0, ready_o}, 32'd1);
        check("abort_valid", {31'd0, valid_o}, 32'd0);
        check("abort_sgf", {8'd0, sgf_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_valid", {31'd0, valid_o}, 32'd0);

        run_op(24'hC00000, 8'h01, 2'b10, 1'b0, 2'b10, 24'hC00001, 8'h01, 1'b0, 1'b1, 3, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
